// File: rtl/ntt_arith_pipe.sv
// Pipelined modular ADD/SUB/MULT unit for the NTT datapath.
// Fixed latency MUL_STAGES+1 for every opcode, with valid/ready flow control on both sides.
module ntt_arith_pipe #(
    parameter int WIDTH      = 64,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_q,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances or holds as one, and it holds only while the
    // output register has a result that the consumer refuses.

    localparam int PW = 2 * WIDTH;
    localparam int CH = (PW + MUL_STAGES - 1) / MUL_STAGES;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [1:0]       op;
        logic             err;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [PW-1:0]    prod;
        logic [WIDTH-1:0] rem;
    } stage_t;

    stage_t src  [MUL_STAGES];
    stage_t st_d [MUL_STAGES];
    stage_t st_q [MUL_STAGES];
    stage_t last;

    logic             stall;
    logic [PW-1:0]    red_p;
    logic [WIDTH-1:0] red_r;
    logic [WIDTH:0]   red_t;
    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] res;
    logic             busy_c;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic [TAG_W-1:0] out_tag_d,   out_tag_q;
    logic             out_err_d,   out_err_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid;
        src[0].op    = in_op;
        src[0].err   = (in_op == 2'd3) || (in_q == '0);
        src[0].tag   = in_tag;
        src[0].a     = in_a;
        src[0].b     = in_b;
        src[0].q     = in_q;
        src[0].prod  = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
        src[0].rem   = '0;
        for (int s = 1; s < MUL_STAGES; s++) begin
            src[s] = st_q[s-1];
        end
    end

    // Product reduced MSB-first: r = (2r + bit) mod q, one conditional
    // subtract per bit since r < q. The 2*WIDTH bits are split across stages.
    always_comb begin
        red_p = '0;
        red_r = '0;
        red_t = '0;
        for (int s = 0; s < MUL_STAGES; s++) begin
            st_d[s] = st_q[s];
            if (!stall) begin
                st_d[s] = src[s];
                red_p   = src[s].prod;
                red_r   = src[s].rem;
                for (int j = 0; j < CH; j++) begin
                    if (s * CH + j < PW) begin
                        red_t = {red_r, red_p[PW-1]};
                        if (red_t >= {1'b0, src[s].q}) begin
                            red_t = red_t - {1'b0, src[s].q};
                        end
                        red_r = red_t[WIDTH-1:0];
                        red_p = red_p << 1;
                    end
                end
                st_d[s].prod = red_p;
                st_d[s].rem  = red_r;
            end
        end
    end

    // ADD/SUB are evaluated at the last stage so they share the MULT latency.
    always_comb begin
        last  = st_q[MUL_STAGES-1];
        add_s = {1'b0, last.a} + {1'b0, last.b};
        if (add_s >= {1'b0, last.q}) begin
            add_s = add_s - {1'b0, last.q};
        end
        if (last.a >= last.b) begin
            sub_r = last.a - last.b;
        end else begin
            sub_r = last.a - last.b + last.q;
        end
        case (last.op)
            OP_ADD:  res = add_s[WIDTH-1:0];
            OP_SUB:  res = sub_r;
            OP_MULT: res = last.rem;
            default: res = '0;
        endcase
        if (last.err) begin
            res = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
        if (!stall) begin
            out_valid_d = last.valid;
            out_data_d  = res;
            out_tag_d   = last.tag;
            out_err_d   = last.err;
        end
    end

    always_comb begin
        busy_c = out_valid_q;
        for (int s = 0; s < MUL_STAGES; s++) begin
            busy_c = busy_c | st_q[s].valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < MUL_STAGES; s++) begin
                st_q[s] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            for (int s = 0; s < MUL_STAGES; s++) begin
                st_q[s] <= st_d[s];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
    assign busy      = busy_c;

endmodule
